// File: rtl/piso_serializer_8bit_if.sv
// Handshake/serial bus for piso_serializer_8bit: upstream word load plus serial output stream.
interface piso_serializer_8bit_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] d_in;
  logic              load_valid;
  logic              load_ready;
  logic              ser_out;
  logic              ser_valid;
  logic              frame_start;
  logic              busy;

  modport master (
    output d_in, load_valid,
    input  load_ready, ser_out, ser_valid, frame_start, busy
  );

  modport slave (
    input  d_in, load_valid,
    output load_ready, ser_out, ser_valid, frame_start, busy
  );
endinterface

// File: rtl/piso_serializer_8bit.sv
// Parallel-in serial-out serializer with registered outputs and back-to-back frame support.
// Define SERIALIZER_PARITY_EN to append an even-parity bit after each frame.
module piso_serializer_8bit #(
  parameter int DATA_W    = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  piso_serializer_8bit_if.slave bus
);

  localparam int              CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
`ifdef SERIALIZER_PARITY_EN
    , PAR = 2'd2
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic              ser_out_q, ser_out_d;
  logic              ser_valid_q, ser_valid_d;
  logic              frame_start_q, frame_start_d;
  logic              busy_q, busy_d;
  logic              load_ready;
  logic              accept;
`ifdef SERIALIZER_PARITY_EN
  logic              parity_q, parity_d;
`endif

  // Ready depends only on state and reset, never on load_valid.
  always_comb begin
    load_ready = 1'b0;
    if (!reset) begin
      case (state_q)
        IDLE:    load_ready = 1'b1;
`ifndef SERIALIZER_PARITY_EN
        SHIFT:   load_ready = (cnt_q == LAST);
`endif
`ifdef SERIALIZER_PARITY_EN
        PAR:     load_ready = 1'b1;
`endif
        default: load_ready = 1'b0;
      endcase
    end
  end

  assign accept = bus.load_valid && load_ready;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    sh_d          = sh_q;
    ser_out_d     = 1'b0;
    ser_valid_d   = 1'b0;
    frame_start_d = 1'b0;
    busy_d        = 1'b0;
`ifdef SERIALIZER_PARITY_EN
    parity_d      = parity_q;
`endif

    case (state_q)
      IDLE: ;
      SHIFT: begin
        if (cnt_q != LAST) begin
          cnt_d       = cnt_q + 1'b1;
          ser_out_d   = LSB_FIRST ? sh_q[0] : sh_q[DATA_W-1];
          sh_d        = LSB_FIRST ? (sh_q >> 1) : (sh_q << 1);
          ser_valid_d = 1'b1;
          busy_d      = 1'b1;
        end else begin
          cnt_d   = '0;
`ifdef SERIALIZER_PARITY_EN
          state_d     = PAR;
          ser_out_d   = parity_q;
          ser_valid_d = 1'b1;
          busy_d      = 1'b1;
`else
          state_d = IDLE;
`endif
        end
      end
`ifdef SERIALIZER_PARITY_EN
      PAR:     state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase

    // A capture overrides the end-of-frame decision so the next frame follows without a gap.
    if (accept) begin
      state_d       = SHIFT;
      cnt_d         = '0;
      ser_out_d     = LSB_FIRST ? bus.d_in[0] : bus.d_in[DATA_W-1];
      sh_d          = LSB_FIRST ? (bus.d_in >> 1) : (bus.d_in << 1);
      ser_valid_d   = 1'b1;
      frame_start_d = 1'b1;
      busy_d        = 1'b1;
`ifdef SERIALIZER_PARITY_EN
      parity_d      = ^bus.d_in;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      sh_q          <= '0;
      ser_out_q     <= 1'b0;
      ser_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
      parity_q      <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sh_q          <= sh_d;
      ser_out_q     <= ser_out_d;
      ser_valid_q   <= ser_valid_d;
      frame_start_q <= frame_start_d;
      busy_q        <= busy_d;
`ifdef SERIALIZER_PARITY_EN
      parity_q      <= parity_d;
`endif
    end
  end

  assign bus.load_ready  = load_ready;
  assign bus.ser_out     = ser_out_q;
  assign bus.ser_valid   = ser_valid_q;
  assign bus.frame_start = frame_start_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_piso_serializer_8bit.sv
// Directed bench for piso_serializer_8bit: one LSB-first and one MSB-first instance on a shared clock.
module tb_piso_serializer_8bit;

`ifdef SERIALIZER_PARITY_EN
  localparam int FRAME = 9;
  localparam bit PAR_EN = 1'b1;
`else
  localparam int FRAME = 8;
  localparam bit PAR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  piso_serializer_8bit_if #(.DATA_W(8)) bus0 ();
  piso_serializer_8bit_if #(.DATA_W(8)) bus1 ();

  piso_serializer_8bit #(.DATA_W(8), .LSB_FIRST(1'b1)) u_lsb (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0.slave)
  );

  piso_serializer_8bit #(.DATA_W(8), .LSB_FIRST(1'b0)) u_msb (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle0(input string tag, input logic exp_ready);
    chk({tag, "_valid"}, bus0.ser_valid, 1'b0);
    chk({tag, "_busy"},  bus0.busy, 1'b0);
    chk({tag, "_out"},   bus0.ser_out, 1'b0);
    chk({tag, "_fs"},    bus0.frame_start, 1'b0);
    chk({tag, "_ready"}, bus0.load_ready, exp_ready);
  endtask

  // seq lists the expected serial bits with the first bit at seq[7]; pulse_at >= 0 injects
  // an ignored load request (with a different word) during that bit.
  task automatic frame_u0(input string tag, input logic [7:0] data, input logic [7:0] seq,
                          input logic par, input int pulse_at);
    bus0.d_in       = data;
    bus0.load_valid = 1'b1;
    tick();
    bus0.load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      chk($sformatf("%s_b%0d", tag, i),     bus0.ser_out, seq[7-i]);
      chk($sformatf("%s_v%0d", tag, i),     bus0.ser_valid, 1'b1);
      chk($sformatf("%s_fs%0d", tag, i),    bus0.frame_start, (i == 0));
      chk($sformatf("%s_busy%0d", tag, i),  bus0.busy, 1'b1);
      chk($sformatf("%s_rdy%0d", tag, i),   bus0.load_ready, (i == 7) && !PAR_EN);
      if (i == pulse_at) begin
        bus0.d_in       = ~data;
        bus0.load_valid = 1'b1;
      end else if (i == pulse_at + 1) begin
        bus0.load_valid = 1'b0;
      end
    end
    if (PAR_EN) begin
      tick();
      chk({tag, "_par"},     bus0.ser_out, par);
      chk({tag, "_par_v"},   bus0.ser_valid, 1'b1);
      chk({tag, "_par_fs"},  bus0.frame_start, 1'b0);
      chk({tag, "_par_rdy"}, bus0.load_ready, 1'b1);
    end
    tick();
    chk_idle0({tag, "_end"}, 1'b1);
  endtask

  logic [0:17] exp_b2b;
  logic [7:0]  seq_c3;

  initial begin
    reset = 1'b1;
    bus0.load_valid = 1'b0;
    bus0.d_in       = '0;
    bus1.load_valid = 1'b0;
    bus1.d_in       = '0;
`ifdef SERIALIZER_PARITY_EN
    exp_b2b = 18'b100000001_000000011;
`else
    exp_b2b = {16'b10000000_00000001, 2'b00};
`endif

    // Reset state
    tick();
    tick();
    chk_idle0("rst", 1'b0);
    chk("rst_msb_valid", bus1.ser_valid, 1'b0);
    reset = 1'b0;
    #1;
    chk("rst_release_ready", bus0.load_ready, 1'b1);

    // Single frames, LSB first
    frame_u0("a5", 8'hA5, 8'b10100101, 1'b0, -10);
    frame_u0("07", 8'h07, 8'b11100000, 1'b1, -10);

    // Load request while busy mid-frame is ignored
    frame_u0("ign", 8'h3C, 8'b00111100, 1'b0, 2);

    // Back-to-back frames with load_valid held high
    bus0.d_in       = 8'h01;
    bus0.load_valid = 1'b1;
    for (int k = 1; k <= 2 * FRAME; k++) begin
      tick();
      chk($sformatf("b2b_v%0d", k),  bus0.ser_valid, 1'b1);
      chk($sformatf("b2b_fs%0d", k), bus0.frame_start, (k == 1) || (k == FRAME + 1));
      chk($sformatf("b2b_b%0d", k),  bus0.ser_out, exp_b2b[k-1]);
      if (k == 1) bus0.d_in = 8'h80;
      if (k == FRAME + 1) bus0.load_valid = 1'b0;
    end
    tick();
    chk_idle0("b2b_end", 1'b1);

    // Reset during the 4th bit aborts the frame
    bus0.d_in       = 8'hFF;
    bus0.load_valid = 1'b1;
    tick();
    bus0.load_valid = 1'b0;
    chk("abort_b0", bus0.ser_out, 1'b1);
    chk("abort_fs", bus0.frame_start, 1'b1);
    tick();
    tick();
    tick();
    chk("abort_b3", bus0.ser_out, 1'b1);
    chk("abort_v3", bus0.ser_valid, 1'b1);
    reset = 1'b1;
    tick();
    chk_idle0("abort_rst", 1'b0);
    reset = 1'b0;
    #1;
    chk("abort_ready", bus0.load_ready, 1'b1);
    tick();
    chk("abort_no_bits_v", bus0.ser_valid, 1'b0);
    tick();
    chk("abort_no_bits_busy", bus0.busy, 1'b0);

    // Reset wins over a simultaneous load
    reset           = 1'b1;
    bus0.d_in       = 8'hFF;
    bus0.load_valid = 1'b1;
    tick();
    reset           = 1'b0;
    bus0.load_valid = 1'b0;
    chk("rstload_v", bus0.ser_valid, 1'b0);
    tick();
    chk_idle0("rstload_idle", 1'b1);

    // MSB first, d_in changed mid-frame
    seq_c3          = 8'b11000011;
    bus1.d_in       = 8'hC3;
    bus1.load_valid = 1'b1;
    tick();
    bus1.load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      chk($sformatf("msb_b%0d", i),  bus1.ser_out, seq_c3[7-i]);
      chk($sformatf("msb_v%0d", i),  bus1.ser_valid, 1'b1);
      chk($sformatf("msb_fs%0d", i), bus1.frame_start, (i == 0));
      if (i == 3) bus1.d_in = 8'h00;
    end
    if (PAR_EN) begin
      tick();
      chk("msb_par", bus1.ser_out, 1'b0);
      chk("msb_par_v", bus1.ser_valid, 1'b1);
    end
    tick();
    chk("msb_end_v", bus1.ser_valid, 1'b0);
    chk("msb_end_busy", bus1.busy, 1'b0);
    chk("lsb_quiet", bus0.ser_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
